// File: rtl/count_seg_scan.sv
// Two-digit multiplexed 7-segment driver for the Q1/Q2 dual counter.
// Registers both counts, scans SHOW0/BLANK0/SHOW1/BLANK1 and flags counter wraps.
module count_seg_scan #(
  parameter int REFRESH_DIV  = 4,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_q1,
  input  logic [2:0] i_q2,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_q1_wrap,
  output logic       o_q2_wrap
);

  // state  | meaning
  // SHOW0  | Q1 digit lit for REFRESH_DIV cycles
  // BLANK0 | one dark cycle before switching to the Q2 digit
  // SHOW1  | Q2 digit lit for REFRESH_DIV cycles
  // BLANK1 | one dark cycle before returning to the Q1 digit
  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  localparam int             DW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(REFRESH_DIV - 1);

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [3:0]    r_q1;
  logic [2:0]    r_q2;
  logic          r_q1_wrap;
  logic          r_q2_wrap;
  logic [6:0]    w_seg;
  logic [1:0]    w_an;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SHOW0;
      r_div     <= '0;
      r_q1      <= '0;
      r_q2      <= '0;
      r_q1_wrap <= 1'b0;
      r_q2_wrap <= 1'b0;
    end else begin
      r_q1      <= i_q1;
      r_q2      <= i_q2;
      r_q1_wrap <= (r_q1 == 4'hF) && (i_q1 == 4'h0);
      r_q2_wrap <= (r_q2 == 3'd7) && (i_q2 == 3'd0);
      // scan position only moves while enabled; en=0 freezes it in place
      if (i_en) begin
        case (r_state)
          SHOW0: begin
            if (r_div == DIV_LAST) begin
              r_div   <= '0;
              r_state <= BLANK0;
            end else begin
              r_div <= r_div + DW'(1);
            end
          end
          BLANK0: r_state <= SHOW1;
          SHOW1: begin
            if (r_div == DIV_LAST) begin
              r_div   <= '0;
              r_state <= BLANK1;
            end else begin
              r_div <= r_div + DW'(1);
            end
          end
          default: r_state <= SHOW0;
        endcase
      end
    end
  end

  // display dark whenever reset or disabled, before polarity is applied
  always_comb begin
    w_an  = 2'b00;
    w_seg = 7'h00;
    if (!i_rst && i_en) begin
      case (r_state)
        SHOW0: begin
          w_an  = 2'b01;
          w_seg = hex7(r_q1);
        end
        SHOW1: begin
          w_an  = 2'b10;
          w_seg = hex7({1'b0, r_q2});
        end
        default: begin
          w_an  = 2'b00;
          w_seg = 7'h00;
        end
      endcase
    end
  end

  assign o_seg     = COMMON_ANODE ? ~w_seg : w_seg;
  assign o_an      = COMMON_ANODE ? ~w_an  : w_an;
  assign o_q1_wrap = r_q1_wrap;
  assign o_q2_wrap = r_q2_wrap;

endmodule

// File: tb/tb_count_seg_scan.sv
// Bench for count_seg_scan: scan-position model checked every cycle plus
// directed literal checks, on an active-high and a common-anode instance.
module tb_count_seg_scan;

  localparam int D      = 4;
  localparam int PERIOD = 2 * D + 2;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // hand-derived scan for Q1=A, Q2=5, indexed by position in the period
  localparam logic [1:0] PAT_AN  [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                         2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam logic [6:0] PAT_SEG [10] = '{7'h77, 7'h77, 7'h77, 7'h77, 7'h00,
                                         7'h6D, 7'h6D, 7'h6D, 7'h6D, 7'h00};

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] q1;
  logic [2:0] q2;
  logic [6:0] seg, seg_ca;
  logic [1:0] an, an_ca;
  logic       w1, w2, w1_ca, w2_ca;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  count_seg_scan #(.REFRESH_DIV(D), .COMMON_ANODE(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_q1(q1), .i_q2(q2),
    .o_seg(seg), .o_an(an), .o_q1_wrap(w1), .o_q2_wrap(w2));

  count_seg_scan #(.REFRESH_DIV(D), .COMMON_ANODE(1'b1)) dut_ca (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_q1(q1), .i_q2(q2),
    .o_seg(seg_ca), .o_an(an_ca), .o_q1_wrap(w1_ca), .o_q2_wrap(w2_ca));

  // model: scan position = enabled cycles since reset, modulo the period
  bit         m_valid = 1'b0;
  int         m_pos;
  logic [3:0] m_q1;
  logic [2:0] m_q2;
  logic       m_w1, m_w2;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_pos   = 0;
      m_q1    = '0;
      m_q2    = '0;
      m_w1    = 1'b0;
      m_w2    = 1'b0;
    end else if (m_valid) begin
      m_w1 = (m_q1 == 4'hF) && (q1 == 4'h0);
      m_w2 = (m_q2 == 3'd7) && (q2 == 3'd0);
      m_q1 = q1;
      m_q2 = q2;
      if (en) m_pos = (m_pos + 1) % PERIOD;
    end
  end

  logic [1:0] e_an;
  logic [6:0] e_seg;

  always @(negedge clk) begin
    if (m_valid) begin
      e_an  = 2'b00;
      e_seg = 7'h00;
      if (!rst && en) begin
        if (m_pos < D) begin
          e_an  = 2'b01;
          e_seg = HEX[m_q1];
        end else if (m_pos > D && m_pos < PERIOD - 1) begin
          e_an  = 2'b10;
          e_seg = HEX[{1'b0, m_q2}];
        end
      end
      n_vec++;
      if (an !== e_an || seg !== e_seg || w1 !== m_w1 || w2 !== m_w2 ||
          an_ca !== ~e_an || seg_ca !== ~e_seg || w1_ca !== m_w1 || w2_ca !== m_w2) begin
        n_miss++;
        $display("FAIL model t=%0t: got an=%b seg=%h w=%b%b ca_an=%b ca_seg=%h ca_w=%b%b, expected an=%b seg=%h w=%b%b",
                 $time, an, seg, w1, w2, an_ca, seg_ca, w1_ca, w2_ca, e_an, e_seg, m_w1, m_w2);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [2:0] b, input logic e, input logic r);
    @(posedge clk);
    #1;
    q1  = a;
    q2  = b;
    en  = e;
    rst = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    q1  = 4'h0;
    q2  = 3'd0;

    // reset: two edges with rst high
    @(negedge clk);
    chk("rst_an", {6'd0, an}, 8'h00);
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_wraps", {6'd0, w1, w2}, 8'h00);
    chk("rst_ca_seg", {1'b0, seg_ca}, 8'h7F);
    cyc(4'h0, 3'd0, 1'b1, 1'b0);
    chk("release_an", {6'd0, an}, 8'h01);
    chk("release_seg", {1'b0, seg}, 8'h3F);

    // full scan with Q1=A, Q2=5
    q1 = 4'hA;
    q2 = 3'd5;
    for (int i = 0; i < 20; i++) begin
      cyc(4'hA, 3'd5, 1'b1, 1'b0);
      chk("scan_an", {6'd0, an}, {6'd0, PAT_AN[(i + 1) % 10]});
      chk("scan_seg", {1'b0, seg}, {1'b0, PAT_SEG[(i + 1) % 10]});
    end

    // wrap detection
    cyc(4'hF, 3'd5, 1'b1, 1'b0);
    cyc(4'h0, 3'd5, 1'b1, 1'b0);
    chk("q1_wrap_pre", {7'd0, w1}, 8'h00);
    cyc(4'h0, 3'd5, 1'b1, 1'b0);
    chk("q1_wrap_pulse", {7'd0, w1}, 8'h01);
    cyc(4'h0, 3'd5, 1'b1, 1'b0);
    chk("q1_wrap_end", {7'd0, w1}, 8'h00);
    cyc(4'hF, 3'd5, 1'b1, 1'b0);
    cyc(4'h1, 3'd5, 1'b1, 1'b0);
    cyc(4'h1, 3'd5, 1'b1, 1'b0);
    chk("q1_f_to_1", {7'd0, w1}, 8'h00);
    cyc(4'h1, 3'd7, 1'b1, 1'b0);
    cyc(4'h1, 3'd0, 1'b1, 1'b0);
    cyc(4'h1, 3'd0, 1'b1, 1'b0);
    chk("q2_wrap_pulse", {6'd0, w1, w2}, 8'h01);
    cyc(4'h1, 3'd0, 1'b1, 1'b0);
    chk("q2_wrap_end", {7'd0, w2}, 8'h00);
    cyc(4'hF, 3'd7, 1'b1, 1'b0);
    cyc(4'h0, 3'd0, 1'b1, 1'b0);
    cyc(4'h0, 3'd0, 1'b1, 1'b0);
    chk("both_wrap", {6'd0, w1, w2}, 8'h03);
    cyc(4'h0, 3'd0, 1'b1, 1'b0);
    chk("both_wrap_end", {6'd0, w1, w2}, 8'h00);

    // known position via reset, then common-anode checks with Q1=8
    cyc(4'h8, 3'd0, 1'b1, 1'b1);
    chk("ca_rst_an", {6'd0, an_ca}, 8'h03);
    for (int i = 0; i < 7; i++) begin
      cyc(4'h8, 3'd0, 1'b1, 1'b0);
      if (i == 1) begin
        chk("ca_show0_seg", {1'b0, seg_ca}, 8'h00);
        chk("ca_show0_an", {6'd0, an_ca}, 8'h02);
      end
      if (i == 4) begin
        chk("ca_blank0_seg", {1'b0, seg_ca}, 8'h7F);
        chk("ca_blank0_an", {6'd0, an_ca}, 8'h03);
      end
    end

    // en=0 while in SHOW1 with div_cnt=2
    for (int i = 0; i < 5; i++) begin
      cyc(4'h8, 3'd0, 1'b0, 1'b0);
      chk("en_off_an", {6'd0, an}, 8'h00);
    end
    cyc(4'h8, 3'd0, 1'b1, 1'b0);
    chk("resume_show1_a", {6'd0, an}, 8'h02);
    cyc(4'h8, 3'd0, 1'b1, 1'b0);
    chk("resume_show1_b", {6'd0, an}, 8'h02);

    // rst pulse during BLANK1
    cyc(4'h8, 3'd0, 1'b1, 1'b1);
    chk("rst_in_blank1", {6'd0, an}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(4'h8, 3'd0, 1'b1, 1'b0);
      chk("after_rst_show0", {6'd0, an}, 8'h01);
    end
    cyc(4'h8, 3'd0, 1'b1, 1'b0);
    chk("after_rst_blank0", {6'd0, an}, 8'h00);

    // directed sweep of values and enable gaps, checked by the model
    for (int i = 0; i < 40; i++) begin
      cyc(4'((i * 5) % 16), 3'((i * 3) % 8), (i % 7) != 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
